// File: rtl/rs232_tx.sv
// ============================================================================
// Module   : rs232_tx
// Purpose  : 8N1 serial transmitter with a run-time programmable bit period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232_tx #(
  parameter int Width = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       data_i,
  input  logic [Width-1:0] baud_max_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  localparam logic [Width-1:0] c_cnt_one = {{(Width-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [Width-1:0] cnt_q,   cnt_d;
  logic [Width-1:0] n_q,     n_d;
  logic [2:0]       idx_q,   idx_d;
  logic             tx_q,    tx_d;
  logic             done_q,  done_d;
  logic             w_bit_end;

  assign w_bit_end = (cnt_q == n_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= c_st_idle;
      shift_q <= 8'h00;
      cnt_q   <= '0;
      n_q     <= '0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (start_i) begin
          shift_d = data_i;
          n_d     = baud_max_i;
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = c_st_start;
        end
      end
      c_st_start: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          state_d = c_st_data;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      c_st_data: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = c_st_stop;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      c_st_stop: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          state_d = c_st_idle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // tx is registered, so its next value follows the state being entered
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      c_st_idle:  tx_d = 1'b1;
      c_st_start: tx_d = 1'b0;
      c_st_data:  tx_d = shift_d[0];
      c_st_stop:  tx_d = 1'b1;
      default:    tx_d = 1'b1;
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != c_st_idle);
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: frame-level reference model plus directed and random stimulus.
`default_nettype none

module tb_rs232_tx;

  localparam int TB_W = 8;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic [7:0]      data_i = 8'h00;
  logic [TB_W-1:0] baud_max_i = '0;
  logic            tx_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;

  rs232_tx #(.Width(TB_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .data_i     (data_i),
    .baud_max_i (baud_max_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a frame is 10 bit slots of (N+1) cycles; slot 0 start, 1..8 data LSB first, 9 stop.
  bit       m_active = 1'b0;
  bit       m_done   = 1'b0;
  int       m_t      = 0;
  int       m_n      = 0;
  bit [7:0] m_byte   = 8'h00;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
    end else if (m_active) begin
      if (m_t + 1 == 10 * (m_n + 1)) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_t    <= m_t + 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start_i) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_n      <= int'(baud_max_i);
        m_byte   <= data_i;
      end
    end
  end

  always @(negedge clk_i) begin
    int  k;
    logic exp_tx;
    exp_tx = 1'b1;
    if (m_active) begin
      k = m_t / (m_n + 1);
      if (k == 0)      exp_tx = 1'b0;
      else if (k <= 8) exp_tx = m_byte[k-1];
      else             exp_tx = 1'b1;
    end
    chk("tx", {31'd0, tx_o}, {31'd0, exp_tx});
    chk("busy", {31'd0, busy_o}, {31'd0, m_active});
    chk("done", {31'd0, done_o}, {31'd0, m_done});
  end

  // One frame; with noise set, inputs are scrambled while the frame runs.
  task automatic run_frame(input logic [7:0] d, input int n, input bit noise);
    int busyc;
    int cyc;
    int len;
    len = 10 * (n + 1);
    @(negedge clk_i); #1;
    start_i    = 1'b1;
    data_i     = d;
    baud_max_i = n[TB_W-1:0];
    @(negedge clk_i);
    busyc = busy_o ? 1 : 0;
    cyc   = 1;
    #1 start_i = 1'b0;
    while (!done_o && cyc < len + 4) begin
      if (noise) begin
        data_i     = 8'hFF;
        baud_max_i = TB_W'(7);
        start_i    = (busyc < len - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk_i);
      if (busy_o) busyc++;
      cyc++;
    end
    start_i = 1'b0;
    chk("busy_len", busyc, len);
    chk("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    int cyc;
    int gap;
    #1 rst_i = 1'b0;
    #2;
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b1;

    // Basic frame, minimum divider, mid-frame input changes.
    run_frame(8'hA5, 3, 1'b0);
    run_frame(8'h00, 0, 1'b0);
    run_frame(8'h3C, 3, 1'b1);
    repeat (12) @(negedge clk_i);
    chk("no_second_frame", {31'd0, busy_o}, 32'd0);

    // Back-to-back frames with start held high.
    #1;
    start_i    = 1'b1;
    data_i     = 8'h81;
    baud_max_i = TB_W'(1);
    cyc = 0;
    while (!done_o && cyc < 40) begin @(negedge clk_i); cyc++; end
    gap = 0;
    do begin @(negedge clk_i); gap++; end while (!done_o && gap < 40);
    chk("b2b_period", gap, 21);
    do begin @(negedge clk_i); gap++; end while (!done_o && gap < 80);
    chk("b2b_period2", gap, 42);
    #1 start_i = 1'b0;
    repeat (25) @(negedge clk_i);

    // Reset during data bit 3.
    #1;
    start_i    = 1'b1;
    data_i     = 8'hC3;
    baud_max_i = TB_W'(3);
    @(negedge clk_i); #1 start_i = 1'b0;
    repeat (17) @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("abort_tx", {31'd0, tx_o}, 32'd1);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b1;
    run_frame(8'h55, 3, 1'b0);

    // Widest divider for this instance.
    run_frame(8'($urandom), (1 << TB_W) - 1, 1'b0);

    // Random traffic; the reference model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i); #1;
      start_i    = ($urandom_range(0, 7) == 0);
      data_i     = 8'($urandom);
      baud_max_i = TB_W'($urandom_range(0, 5));
      if ($urandom_range(0, 999) == 0) begin
        rst_i = 1'b0;
        #2 rst_i = 1'b1;
      end
    end
    start_i = 1'b0;
    repeat (70) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/rs232_tx.md
RS232_TX -- requirements
Module: rs232_tx

Interface
REQ-001 SHALL have parameter Width, default 15: bit width of the baud divider counter and of baud_max_i.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start_i, input, 1 bit: transmit request, sampled only while idle.
REQ-005 SHALL have port data_i, input, 8 bits: byte to transmit, captured when a request is accepted.
REQ-006 SHALL have port baud_max_i, input, Width bits: bit period minus one, in clk_i cycles.
REQ-007 SHALL have port tx_o, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port busy_o, output, 1 bit: high while a frame is in progress.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse on frame completion.

Function
REQ-010 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 SHALL accept a request in IDLE when start_i=1 at a rising edge, and at that same edge:
  - capture data_i into an 8-bit shift register;
  - capture baud_max_i into an internal register (N);
  - clear the baud counter and the bit index;
  - enter START.
REQ-013 SHALL time each bit with an internal Width-bit counter counting 0..N; a bit ends on the cycle the count equals N; the counter then wraps to 0.
REQ-014 SHALL hold each bit on tx_o for exactly N+1 clk_i cycles; N=0 gives one cycle per bit.
REQ-015 SHALL make tx_o a registered output with these values:
  - IDLE: 1;
  - START: 0;
  - DATA: current shift-register LSB;
  - STOP: 1.
REQ-016 SHALL shift the data register right by one at the end of each DATA bit and increment the 3-bit bit index.
REQ-017 SHALL go from START to DATA at the end of the start bit.
REQ-018 SHALL go from DATA to STOP at the end of the bit whose index is 7.
REQ-019 SHALL go from STOP to IDLE at the end of the stop bit; a full frame is 10*(N+1) cycles.
REQ-020 SHALL drive busy_o=1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 SHALL assert done_o for exactly the first IDLE cycle after STOP, and 0 otherwise.
REQ-022 SHALL ignore start_i, data_i and baud_max_i while busy_o=1; changing these inputs mid-frame SHALL NOT alter the frame.
REQ-023 SHALL allow back-to-back frames:
  - start_i=1 during the done_o cycle is accepted;
  - the next start bit follows the previous stop bit with no extra idle cycles beyond that one.
REQ-024 SHALL start a new frame on every accepted edge when start_i is held high continuously.

Reset
REQ-025 SHALL, while rst_i=0 and regardless of clk_i:
  - force state IDLE;
  - tx_o=1, busy_o=0, done_o=0;
  - clear the baud counter, bit index, shift register and N.
REQ-026 SHALL abort any frame in progress on reset and leave tx_o high; no done_o pulse for an aborted frame.
REQ-027 SHALL accept a request on the first rising edge after rst_i returns high.

Verification
REQ-028 SHALL cover a basic frame:
  - stimulus: baud_max_i=3, data_i=0xA5, one-cycle start_i;
  - response: tx_o = 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles;
  - busy_o high for 40 cycles, then done_o high for 1 cycle.
REQ-029 SHALL cover the minimum divider:
  - stimulus: baud_max_i=0, data_i=0x00;
  - response: tx_o low for 9 cycles, high for 1; frame is 10 cycles; done_o on cycle 11.
REQ-030 SHALL cover inputs changing mid-frame:
  - stimulus: baud_max_i=3, data_i=0x3C accepted; then data_i=0xFF, baud_max_i=7 and start_i pulses during the frame;
  - response: the transmitted byte is 0x3C at 4 cycles per bit; no second frame starts.
REQ-031 SHALL cover back-to-back frames:
  - stimulus: start_i held high, data_i=0x81, baud_max_i=1;
  - response: consecutive 20-cycle frames, each separated by exactly one IDLE cycle in which done_o=1.
REQ-032 SHALL cover reset mid-frame:
  - stimulus: rst_i=0 during data bit 3;
  - response: tx_o=1 and busy_o=0 immediately, with no done_o pulse;
  - after release, a new 0x55 frame transmits correctly.
REQ-033 SHALL cover a wide divider:
  - stimulus: baud_max_i=2^Width-1;
  - response: each bit lasts 2^Width cycles; the counter wraps without overflow error.
